// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - memory-access pipeline stage with Wishbone-style data bus
module stage_mem #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic        is_ld_mem_i,
    input  logic        is_st_mem_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_d_i,
    input  logic [31:0] st_d_i,
    output logic        stall_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_dat_o,
    output logic [3:0]  dbus_sel_o,
    output logic        dbus_we_o,
    output logic        dbus_cyc_o,
    output logic        dbus_stb_o,
    input  logic [31:0] dbus_dat_i,
    input  logic        dbus_ack_i,
    input  logic        dbus_err_i,
    output logic        valid_o,
    output logic [31:0] mem_d_o,
    output logic [31:0] alu_d_o,
    output logic [31:0] mem_addr_o,
    output logic        e_ld_addr_mis_o,
    output logic        e_st_addr_mis_o,
    output logic        e_bus_err_o
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          killed;
    logic          aligned, acc, issue, timeout, wait_err, wait_ok, live;
    logic [3:0]    st_sel;
    logic [31:0]   st_dat, lane_sh, ld_data;

    // Request captured at issue so the bus stays stable even if EX/MEM is flushed
    logic [31:0]   req_addr, req_dat;
    logic [3:0]    req_sel;
    logic          req_we, req_ld;
    logic [2:0]    req_f3;
    logic [1:0]    req_lane;

    // Reset gates issue so cyc/stb drop as soon as rst_i rises
    assign acc      = valid_i & (is_ld_mem_i | is_st_mem_i) & aligned & ~flush_i;
    assign issue    = (state == S_IDLE) & acc & ~rst_i;
    assign timeout  = (state == S_WAIT) & (cnt == CNT_LAST);
    assign wait_err = (state == S_WAIT) & (dbus_err_i | timeout);
    assign wait_ok  = (state == S_WAIT) & dbus_ack_i & ~wait_err;
    assign live     = valid_i & ~flush_i & ~killed;
    assign dbus_stb_o = dbus_cyc_o;

    // Alignment check by access size; f3[1:0]=11 behaves as word
    always_comb begin
        aligned = 1'b1;
        case (funct3_i[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~alu_d_i[0];
            default: aligned = (alu_d_i[1:0] == 2'b00);
        endcase
    end

    // Byte-lane enables and lane-replicated write data
    always_comb begin
        st_sel = 4'b1111;
        st_dat = st_d_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_sel = 4'b0001 << alu_d_i[1:0];
                st_dat = {4{st_d_i[7:0]}};
            end
            2'b01: begin
                st_sel = alu_d_i[1] ? 4'b1100 : 4'b0011;
                st_dat = {2{st_d_i[15:0]}};
            end
            default: begin
                st_sel = 4'b1111;
                st_dat = st_d_i;
            end
        endcase
    end

    // Bus FSM next state, bus outputs and stall
    always_comb begin
        state_nx    = state;
        stall_o     = 1'b0;
        dbus_cyc_o  = 1'b0;
        dbus_addr_o = 32'h0;
        dbus_dat_o  = 32'h0;
        dbus_sel_o  = 4'h0;
        dbus_we_o   = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    dbus_cyc_o  = 1'b1;
                    dbus_addr_o = {alu_d_i[31:2], 2'b00};
                    dbus_dat_o  = st_dat;
                    dbus_sel_o  = st_sel;
                    dbus_we_o   = is_st_mem_i;
                    stall_o     = 1'b1;
                    state_nx    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (timeout) begin
                    state_nx = S_IDLE;
                end else begin
                    dbus_cyc_o  = 1'b1;
                    dbus_addr_o = req_addr;
                    dbus_dat_o  = req_dat;
                    dbus_sel_o  = req_sel;
                    dbus_we_o   = req_we;
                    if (dbus_ack_i | dbus_err_i) state_nx = S_IDLE;
                    else                         stall_o  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Load data lane extraction and sign/zero extension
    always_comb begin
        lane_sh = dbus_dat_i >> {req_lane, 3'b000};
        ld_data = lane_sh;
        case (req_f3)
            3'b000:  ld_data = {{24{lane_sh[7]}}, lane_sh[7:0]};
            3'b001:  ld_data = {{16{lane_sh[15]}}, lane_sh[15:0]};
            3'b100:  ld_data = {24'h0, lane_sh[7:0]};
            3'b101:  ld_data = {16'h0, lane_sh[15:0]};
            default: ld_data = lane_sh;
        endcase
    end

    // FSM state, wait counter, kill flag and captured request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            killed   <= 1'b0;
            req_addr <= 32'h0;
            req_dat  <= 32'h0;
            req_sel  <= 4'h0;
            req_we   <= 1'b0;
            req_ld   <= 1'b0;
            req_f3   <= 3'h0;
            req_lane <= 2'h0;
        end else begin
            state <= state_nx;
            if (state == S_WAIT && state_nx == S_WAIT) cnt <= cnt + 1'b1;
            else                                       cnt <= '0;
            if (state_nx == S_IDLE)                    killed <= 1'b0;
            else if (state == S_WAIT && flush_i)       killed <= 1'b1;
            if (issue) begin
                req_addr <= {alu_d_i[31:2], 2'b00};
                req_dat  <= st_dat;
                req_sel  <= st_sel;
                req_we   <= is_st_mem_i;
                req_ld   <= is_ld_mem_i;
                req_f3   <= funct3_i;
                req_lane <= alu_d_i[1:0];
            end
        end
    end

    // MEM/WB pipeline register, advances whenever the stage is not stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o         <= 1'b0;
            mem_d_o         <= 32'h0;
            alu_d_o         <= 32'h0;
            mem_addr_o      <= 32'h0;
            e_ld_addr_mis_o <= 1'b0;
            e_st_addr_mis_o <= 1'b0;
            e_bus_err_o     <= 1'b0;
        end else if (!stall_o) begin
            valid_o         <= live;
            mem_d_o         <= (live & wait_ok & req_ld) ? ld_data : 32'h0;
            alu_d_o         <= alu_d_i;
            mem_addr_o      <= alu_d_i;
            e_ld_addr_mis_o <= live & is_ld_mem_i & ~aligned;
            e_st_addr_mis_o <= live & is_st_mem_i & ~aligned;
            e_bus_err_o     <= live & wait_err;
        end
    end
endmodule
